// File: rtl/pre_mult_stage.sv
// DSP48A1 input / pre-adder / multiplier stage.
// Feeds the X-mux concatenation, product and carry-in to the post-adder stage.
module pre_mult_reg #(
  parameter int unsigned W  = 18,
  parameter int unsigned EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (EN != 0) begin : g_reg
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
      q_d = q_q;
      if (ce) q_d = d;
    end

    always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
    end

    assign q = q_q;
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end
endmodule

module pre_mult_stage #(
  parameter int unsigned A0REG      = 0,
  parameter int unsigned A1REG      = 1,
  parameter int unsigned B0REG      = 0,
  parameter int unsigned B1REG      = 1,
  parameter int unsigned DREG       = 1,
  parameter int unsigned MREG       = 1,
  parameter int unsigned OPMODE_REG = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter string       B_INPUT    = "DIRECT",
  parameter string       CARRYINSEL = "OPMODE5"
) (
  input  logic        clk,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTOPMODE,
  input  logic        RSTCARRYIN,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic        CARRYIN,
  input  logic        opmode4,
  input  logic        opmode5,
  input  logic        opmode6,
  output logic [47:0] DAB,
  output logic [35:0] m_reg,
  output logic        cin,
  output logic [17:0] BCOUT
);
  if (B_INPUT != "DIRECT" && B_INPUT != "CASCADE") begin : g_bad_b
    $error("pre_mult_stage: illegal B_INPUT value");
  end
  if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_c
    $error("pre_mult_stage: illegal CARRYINSEL value");
  end

  logic [17:0] a0_q;
  logic [17:0] a1_q;
  logic [17:0] b0_d;
  logic [17:0] b0_q;
  logic [17:0] b1_d;
  logic [17:0] b1_q;
  logic [17:0] d_q;
  logic [17:0] pre_d;
  logic [2:0]  op_q;
  logic        cy_d;
  logic        cy_q;
  logic [35:0] m_d;
  logic [35:0] m_q;

  assign b0_d = (B_INPUT == "CASCADE") ? BCIN : B;
  assign cy_d = (CARRYINSEL == "OPMODE5") ? op_q[1] : CARRYIN;

  pre_mult_reg #(.W(18), .EN(A0REG)) u_a0 (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q)
  );
  pre_mult_reg #(.W(18), .EN(A1REG)) u_a1 (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q)
  );
  pre_mult_reg #(.W(18), .EN(B0REG)) u_b0 (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b0_d), .q(b0_q)
  );
  pre_mult_reg #(.W(18), .EN(DREG)) u_d (
    .clk(clk), .rst(RSTD), .ce(CED), .d(D), .q(d_q)
  );
  pre_mult_reg #(.W(3), .EN(OPMODE_REG)) u_op (
    .clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE),
    .d({opmode6, opmode5, opmode4}), .q(op_q)
  );

  // Pre-adder wraps modulo 2^18, no saturation
  always_comb begin
    pre_d = d_q + b0_q;
    if (op_q[2]) pre_d = d_q - b0_q;
    b1_d = op_q[0] ? pre_d : b0_q;
  end

  pre_mult_reg #(.W(18), .EN(B1REG)) u_b1 (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1_q)
  );

  assign m_d = $signed(a1_q) * $signed(b1_q);

  pre_mult_reg #(.W(36), .EN(MREG)) u_m (
    .clk(clk), .rst(RSTM), .ce(CEM), .d(m_d), .q(m_q)
  );
  pre_mult_reg #(.W(1), .EN(CARRYINREG)) u_cy (
    .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cy_d), .q(cy_q)
  );

  assign DAB   = {d_q[11:0], a1_q, b1_q};
  assign m_reg = m_q;
  assign cin   = cy_q;
  assign BCOUT = b1_q;
endmodule

// File: tb/tb_pre_mult_stage.sv
// Scoreboard bench for pre_mult_stage: directed corner cases then random
// traffic checked against an arithmetic history model.
module tb_pre_mult_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RSTA, RSTB, RSTD, RSTM, RSTOPMODE, RSTCARRYIN;
  logic CEA, CEB, CED, CEM, CEOPMODE, CECARRYIN;
  logic [17:0] A, B, BCIN, D;
  logic CARRYIN, opmode4, opmode5, opmode6;
  logic [47:0] DAB, DAB2;
  logic [35:0] m_reg, m_reg2;
  logic cin, cin2;
  logic [17:0] BCOUT, BCOUT2;

  pre_mult_stage dut (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTD(RSTD), .RSTM(RSTM),
    .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CED(CED), .CEM(CEM),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .A(A), .B(B), .BCIN(BCIN), .D(D), .CARRYIN(CARRYIN),
    .opmode4(opmode4), .opmode5(opmode5), .opmode6(opmode6),
    .DAB(DAB), .m_reg(m_reg), .cin(cin), .BCOUT(BCOUT)
  );

  pre_mult_stage #(.B_INPUT("CASCADE"), .CARRYINSEL("CARRYIN")) dut2 (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTD(RSTD), .RSTM(RSTM),
    .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CED(CED), .CEM(CEM),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .A(A), .B(B), .BCIN(BCIN), .D(D), .CARRYIN(CARRYIN),
    .opmode4(opmode4), .opmode5(opmode5), .opmode6(opmode6),
    .DAB(DAB2), .m_reg(m_reg2), .cin(cin2), .BCOUT(BCOUT2)
  );

  typedef struct {
    string       name;
    bit          cd, cm, cc, cb, c2;
    logic [47:0] dab;
    logic [35:0] m;
    logic        ci;
    logic [17:0] bc;
    logic [17:0] bc2;
    logic        ci2;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  function automatic exp_t mk(string n);
    exp_t e;
    e.name = n;
    e.cd = 0; e.cm = 0; e.cc = 0; e.cb = 0; e.c2 = 0;
    e.dab = '0; e.m = '0; e.ci = 1'b0;
    e.bc = '0; e.bc2 = '0; e.ci2 = 1'b0;
    return e;
  endfunction

  task automatic chk(string nm, logic [47:0] got, logic [47:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor: pops whatever the stimulus queued for the latest edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.cd) chk({e.name, ".DAB"}, DAB, e.dab);
        if (e.cm) chk({e.name, ".m_reg"}, {12'd0, m_reg}, {12'd0, e.m});
        if (e.cc) chk({e.name, ".cin"}, {47'd0, cin}, {47'd0, e.ci});
        if (e.cb) chk({e.name, ".BCOUT"}, {30'd0, BCOUT}, {30'd0, e.bc});
        if (e.c2) begin
          chk({e.name, ".BCOUT2"}, {30'd0, BCOUT2}, {30'd0, e.bc2});
          chk({e.name, ".cin2"}, {47'd0, cin2}, {47'd0, e.ci2});
        end
      end
    end
  end

  task automatic step(input exp_t e, input bit push);
    @(posedge clk);
    #1;
    if (push) q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Reference arithmetic: 18-bit wrapping pre-adder and exact signed product
  function automatic logic [17:0] b1_of(bit o4, bit o6, logic [17:0] d,
                                        logic [17:0] b);
    int r;
    if (!o4) return b;
    r = o6 ? (int'(d) - int'(b)) : (int'(d) + int'(b));
    return r[17:0];
  endfunction

  function automatic logic [35:0] mul(logic [17:0] a, logic [17:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (a[17]) sa -= 262144;
    if (b[17]) sb -= 262144;
    p = sa * sb;
    return p[35:0];
  endfunction

  localparam int N = 200;
  logic [17:0] ha[N], hb[N], hd[N], hbc[N], hb1[N], hb1c[N];
  bit h4[N], h5[N], h6[N], hcy[N];

  initial begin
    exp_t e;
    {RSTA, RSTB, RSTD, RSTM, RSTOPMODE, RSTCARRYIN} = '1;
    {CEA, CEB, CED, CEM, CEOPMODE, CECARRYIN} = '1;
    A = 18'h3FFFF; B = 18'h3FFFF; D = 18'h3FFFF; BCIN = 18'h3FFFF;
    CARRYIN = 1'b1; opmode4 = 1'b1; opmode5 = 1'b1; opmode6 = 1'b1;

    e = mk("reset");
    e.cd = 1; e.cm = 1; e.cc = 1; e.cb = 1; e.c2 = 1;
    step(e, 1);

    {RSTA, RSTB, RSTD, RSTM, RSTOPMODE, RSTCARRYIN} = '0;
    A = 18'd3; B = 18'd5; D = 18'd0; BCIN = 18'd0; CARRYIN = 1'b0;
    opmode4 = 0; opmode5 = 0; opmode6 = 0;
    e = mk("mul_e1");
    e.cd = 1; e.dab = {12'd0, 18'd3, 18'd5}; e.cm = 1; e.m = '0;
    e.cb = 1; e.bc = 18'd5;
    step(e, 1);
    e = mk("mul_e2"); e.cm = 1; e.m = 36'd15;
    step(e, 1);

    D = 18'd10; B = 18'd4; A = 18'd2; opmode4 = 1; opmode6 = 0;
    step(e, 0);
    e = mk("add_e2");
    e.cb = 1; e.bc = 18'd14; e.cd = 1; e.dab = {12'd10, 18'd2, 18'd14};
    step(e, 1);
    e = mk("add_e3"); e.cm = 1; e.m = 36'd28;
    step(e, 1);
    opmode6 = 1;
    step(e, 0);
    e = mk("sub_e2"); e.cb = 1; e.bc = 18'd6;
    step(e, 1);
    e = mk("sub_e3"); e.cm = 1; e.m = 36'd12;
    step(e, 1);

    D = 18'h3FFFF; B = 18'd1; opmode6 = 0;
    step(e, 0);
    e = mk("wrap_add"); e.cb = 1; e.bc = 18'd0;
    step(e, 1);
    D = 18'd0; opmode6 = 1;
    step(e, 0);
    e = mk("wrap_sub"); e.cb = 1; e.bc = 18'h3FFFF;
    step(e, 1);
    A = 18'h3FFFF; B = 18'd2; opmode4 = 0;
    step(e, 0);
    step(e, 0);
    e = mk("neg_mul"); e.cm = 1; e.m = 36'hFFFFFFFFE;
    e.cd = 1; e.dab = {12'd0, 18'h3FFFF, 18'd2};
    step(e, 1);

    CEM = 0;
    for (int i = 0; i < 3; i++) begin
      A = 18'(5 + i);
      e = mk("cem_hold"); e.cm = 1; e.m = 36'hFFFFFFFFE;
      step(e, 1);
    end
    RSTM = 1; A = 18'd8;
    e = mk("rstm"); e.cm = 1; e.m = '0;
    e.cd = 1; e.dab = {12'd0, 18'd8, 18'd2};
    step(e, 1);
    RSTM = 0; CEM = 1;
    e = mk("rstm_after"); e.cm = 1; e.m = 36'd16;
    step(e, 1);

    BCIN = 18'd7; B = 18'd9;
    e = mk("cascade"); e.cb = 1; e.bc = 18'd9;
    e.c2 = 1; e.bc2 = 18'd7; e.ci2 = 1'b0;
    step(e, 1);
    opmode5 = 1; CARRYIN = 1;
    e = mk("cy_e1"); e.cc = 1; e.ci = 1'b0;
    e.c2 = 1; e.bc2 = 18'd7; e.ci2 = 1'b1;
    step(e, 1);
    e = mk("cy_e2"); e.cc = 1; e.ci = 1'b1;
    step(e, 1);
    RSTCARRYIN = 1;
    e = mk("cy_rst"); e.cc = 1; e.ci = 1'b0;
    e.c2 = 1; e.bc2 = 18'd7; e.ci2 = 1'b0;
    step(e, 1);
    RSTCARRYIN = 0;

    // Random traffic, all enables on: outputs follow from input history
    for (int i = 0; i < N; i++) begin
      ha[i] = 18'($urandom); hb[i] = 18'($urandom);
      hd[i] = 18'($urandom); hbc[i] = 18'($urandom);
      h4[i] = 1'($urandom); h5[i] = 1'($urandom);
      h6[i] = 1'($urandom); hcy[i] = 1'($urandom);
      A = ha[i]; B = hb[i]; D = hd[i]; BCIN = hbc[i];
      opmode4 = h4[i]; opmode5 = h5[i]; opmode6 = h6[i];
      CARRYIN = hcy[i];
      if (i >= 1) begin
        hb1[i]  = b1_of(h4[i-1], h6[i-1], hd[i-1], hb[i]);
        hb1c[i] = b1_of(h4[i-1], h6[i-1], hd[i-1], hbc[i]);
      end
      e = mk("rand");
      if (i >= 2) begin
        e.cd = 1; e.dab = {hd[i][11:0], ha[i], hb1[i]};
        e.cm = 1; e.m = mul(ha[i-1], hb1[i-1]);
        e.cc = 1; e.ci = h5[i-1];
        e.cb = 1; e.bc = hb1[i];
        e.c2 = 1; e.bc2 = hb1c[i]; e.ci2 = hcy[i];
      end
      step(e, i >= 2);
    end

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
